// File: rtl/iram_pkg.sv
// Shared types and helpers for the loadable instruction RAM.
// State encoding, default HALT encoding, parity and byte-to-word address mapping.
package iram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [15:0] HALT_WORD_DEFAULT = 16'h0001;
    localparam int          PARITY_MAX_W      = 64;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

    // Instructions are 16-bit, so the word index drops the byte-select bit.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 1;
    endfunction

endpackage

// File: rtl/iram_core.sv
// Word storage: one write port, one registered read port, optional parity column (IRAM_PARITY_EN).
// Latency: read data one cycle after rd_en. Backpressure: none, accepts one read and one write per cycle.
module iram_core
    import iram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_par_err
);

    if (DATA_W > PARITY_MAX_W) begin : g_bad_data_w
        $error("iram_core: DATA_W exceeds parity helper width");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Only the output register is reset; the array itself is swept by CLEAR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
    end

`ifdef IRAM_PARITY_EN
    logic par_mem [DEPTH];
    logic rd_par;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            par_mem[wr_idx] <= even_parity(PARITY_MAX_W'(wr_dat));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_par <= 1'b0;
        end else if (rd_en) begin
            rd_par <= par_mem[rd_idx];
        end
    end

    assign rd_par_err = (rd_par != even_parity(PARITY_MAX_W'(rd_dat)));
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/iram_loadable.sv
// Instruction RAM: zero-fill after reset, stream-load a program, then serve fetches (parity via IRAM_PARITY_EN).
// Latency: fetch result one cycle after FETCH_REQ. Backpressure: LOAD_READY high only in LOAD; fetches never stall.
module iram_loadable
    import iram_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 128,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_LAST,
    input  logic              FETCH_REQ,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              Q_VALID,
    output logic              HALT_HIT,
    output logic              MISALIGNED,
    output logic              LOAD_OVF,
    output logic              BUSY,
    output logic              PARITY_ERR
);

    localparam int              IDX_W   = ADDR_W - 1;
    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(DEPTH - 1);

    if (ADDR_W != $clog2(DEPTH) + 1) begin : g_bad_addr_w
        $error("iram_loadable: ADDR_W must equal log2(DEPTH)+1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iram_loadable: DEPTH must be a power of two, at least 2");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               ovf_q, ovf_set;
    logic               q_vld_q;
    logic               mis_q;

    logic               wr_en;
    logic [DATA_W-1:0]  wr_dat;
    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_dat;
    logic               rd_par_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_set = 1'b0;
        wr_en   = 1'b0;
        wr_dat  = '0;
        case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == PTR_MAX) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (LOAD_VALID) begin
                    wr_en  = 1'b1;
                    wr_dat = LOAD_DATA;
                    ptr_d  = ptr_q + IDX_W'(1);
                    if (LOAD_LAST) begin
                        state_d = ST_RUN;
                    end else if (ptr_q == PTR_MAX) begin
                        // Memory full without a LAST marker: stop accepting.
                        state_d = ST_RUN;
                        ovf_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign rd_en  = (state_q == ST_RUN) && FETCH_REQ;
    assign rd_idx = IDX_W'(word_index(32'(ADDR)));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_vld_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            q_vld_q <= rd_en;
            mis_q   <= rd_en && ADDR[0];
        end
    end

    iram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .CLK        (CLK),
        .RESET      (RESET),
        .wr_en      (wr_en),
        .wr_idx     (ptr_q),
        .wr_dat     (wr_dat),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_dat     (rd_dat),
        .rd_par_err (rd_par_err)
    );

    assign LOAD_READY = (state_q == ST_LOAD);
    assign BUSY       = (state_q != ST_RUN);
    assign LOAD_OVF   = ovf_q;
    assign Q          = rd_dat;
    assign Q_VALID    = q_vld_q;
    assign MISALIGNED = mis_q;
    assign HALT_HIT   = q_vld_q && (rd_dat == HALT_WORD);
    assign PARITY_ERR = q_vld_q && rd_par_err;

endmodule
